// File: rtl/bist_addr_gen.sv
// Programmable BIST address sequencer: sweeps [lo, hi] up or down for a number
// of passes, optionally alternating direction, with stall back-pressure.
module bist_addr_gen #(
    parameter int WIDTH  = 12,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic              dir,
    input  logic              alt,
    input  logic [PASS_W-1:0] passes,
    input  logic              stall,
    output logic [WIDTH-1:0]  addr,
    output logic              valid,
    output logic              last,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    addr_q, lo_q, hi_q;
    logic [PASS_W-1:0]   pass_idx_q, passes_q;
    logic                dir_q, alt_q;
    logic                valid_q, busy_q, done_q, err_q;
    logic                at_end;
    logic                dir_d;

    // End-of-pass is decided on the current address, before stepping,
    // so windows touching 0 or the top of the range never wrap.
    assign at_end = dir_q ? (addr_q == lo_q) : (addr_q == hi_q);
    assign dir_d  = alt_q ? ~dir_q : dir_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            pass_idx_q <= '0;
            passes_q   <= '0;
            dir_q      <= 1'b0;
            alt_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if ((lo <= hi) && (passes != '0)) begin
                            lo_q       <= lo;
                            hi_q       <= hi;
                            dir_q      <= dir;
                            alt_q      <= alt;
                            passes_q   <= passes;
                            addr_q     <= dir ? hi : lo;
                            pass_idx_q <= '0;
                            valid_q    <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (!at_end) begin
                            addr_q <= dir_q ? addr_q - WIDTH'(1) : addr_q + WIDTH'(1);
                        end else if (pass_idx_q != passes_q - PASS_W'(1)) begin
                            // Next pass starts immediately: no bubble at the boundary.
                            pass_idx_q <= pass_idx_q + PASS_W'(1);
                            dir_q      <= dir_d;
                            addr_q     <= dir_d ? hi_q : lo_q;
                        end else begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr     = addr_q;
    assign valid    = valid_q;
    assign last     = valid_q & at_end;
    assign pass_idx = pass_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bist_addr_gen.sv
// Self-checking bench for bist_addr_gen: directed scenarios plus random
// sequences compared against a beat-list reference model.
module tb_bist_addr_gen;

    localparam int WIDTH  = 12;
    localparam int PASS_W = 4;

    logic              clk = 1'b0;
    logic              rst_n, start, dir, alt, stall;
    logic [WIDTH-1:0]  lo, hi;
    logic [PASS_W-1:0] passes;
    logic [WIDTH-1:0]  addr;
    logic              valid, last, busy, done, err;
    logic [PASS_W-1:0] pass_idx;

    bist_addr_gen #(.WIDTH(WIDTH), .PASS_W(PASS_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lo(lo), .hi(hi), .dir(dir),
        .alt(alt), .passes(passes), .stall(stall), .addr(addr), .valid(valid),
        .last(last), .pass_idx(pass_idx), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int p;
        bit l;
    } beat_t;

    beat_t q[$];
    bit    m_busy, m_done, m_err;
    int    h_addr, h_pidx;
    int    n_vec, n_err, n_done, n_errp, consumed;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expand an accepted configuration into the full list of expected beats.
    task automatic build();
        int n = int'(hi) - int'(lo) + 1;
        for (int p = 0; p < int'(passes); p++) begin
            bit d = dir ^ (alt & p[0]);
            for (int k = 0; k < n; k++) begin
                beat_t b;
                b.a = d ? int'(hi) - k : int'(lo) + k;
                b.p = p;
                b.l = (k == n - 1);
                q.push_back(b);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_busy = 0; m_done = 0; m_err = 0; h_addr = 0; h_pidx = 0;
        end else begin
            m_done = 0;
            m_err  = 0;
            if (!m_busy) begin
                if (start) begin
                    if (lo <= hi && passes != 0) begin
                        build();
                        m_busy = 1;
                    end else begin
                        m_err = 1;
                    end
                end
            end else if (!stall) begin
                h_addr = q[0].a;
                h_pidx = q[0].p;
                void'(q.pop_front());
                consumed++;
                if (q.size() == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
        @(negedge clk);
        chk("valid", int'(valid), int'(m_busy));
        chk("busy", int'(busy), int'(m_busy));
        chk("addr", int'(addr), m_busy ? q[0].a : h_addr);
        chk("pass_idx", int'(pass_idx), m_busy ? q[0].p : h_pidx);
        chk("last", int'(last), m_busy ? int'(q[0].l) : 0);
        chk("done", int'(done), int'(m_done));
        chk("err", int'(err), int'(m_err));
        if (done) n_done++;
        if (err) n_errp++;
        start = 0;
    endtask

    task automatic cfg(input int l, input int h, input bit d, input bit a, input int p);
        lo = WIDTH'(l); hi = WIDTH'(h); dir = d; alt = a; passes = PASS_W'(p);
    endtask

    // Drive until the model goes idle, with optional random stall and
    // spurious starts (which carry a different config and must be ignored).
    task automatic run_to_idle(input bit rnd_stall, input bit rnd_start);
        int budget = 2000;
        while (m_busy && budget > 0) begin
            stall = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (rnd_start && $urandom_range(0, 7) == 0) begin
                start = 1;
                lo = WIDTH'($urandom);
                hi = WIDTH'($urandom);
            end
            step();
            budget--;
        end
        chk("run_timeout", int'(m_busy), 0);
        stall = 0;
        step();
    endtask

    initial begin
        int sc, d0;
        n_vec = 0; n_err = 0; consumed = 0;
        m_busy = 0; m_done = 0; m_err = 0; h_addr = 0; h_pidx = 0;
        rst_n = 0; start = 0; stall = 0;
        cfg(0, 0, 0, 0, 0);

        repeat (16) step();
        rst_n = 1;
        n_done = 0; n_errp = 0;
        repeat (16) step();
        chk("reset_no_pulse", n_done + n_errp, 0);

        // Single ascending pass; done timing checked by the model each cycle.
        cfg(0, 15, 0, 0, 1);
        start = 1;
        step();
        n_done = 0;
        repeat (16) step();
        chk("asc_done_t17", n_done, 1);
        step();

        // Alternating three passes at the top of the range.
        cfg(4090, 4095, 0, 1, 3);
        start = 1;
        step();
        consumed = 0;
        run_to_idle(0, 0);
        chk("alt_beats", consumed, 18);

        // Stall 5 cycles at address 7: done slips to t+22.
        cfg(0, 15, 0, 0, 1);
        start = 1;
        step();
        sc = 0;
        d0 = 0;
        n_done = 0;
        for (int i = 0; i < 21; i++) begin
            stall = (m_busy && q[0].a == 7 && sc < 5);
            if (stall) sc++;
            step();
            if (i == 20) d0 = n_done;
        end
        stall = 0;
        chk("stall_done_t22", d0, 1);
        step();

        // Rejected starts.
        cfg(10, 9, 0, 0, 1);
        start = 1;
        step();
        step();
        cfg(0, 5, 0, 0, 0);
        start = 1;
        step();
        step();

        // Start during RUN ignored.
        cfg(100, 120, 1, 1, 2);
        start = 1;
        step();
        consumed = 0;
        run_to_idle(0, 1);
        chk("ignore_start_beats", consumed, 42);

        // Reset mid-run at beat 20: no done afterwards.
        cfg(0, 63, 1, 0, 2);
        start = 1;
        step();
        consumed = 0;
        while (consumed < 20) step();
        rst_n = 0;
        step();
        rst_n = 1;
        n_done = 0;
        repeat (10) step();
        chk("reset_mid_no_done", n_done, 0);

        // Random sequences, including edge windows and back-to-back starts.
        for (int s = 0; s < 60; s++) begin
            int l = (s % 4 == 0) ? int'($urandom_range(4080, 4095)) :
                    (s % 4 == 1) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 4095));
            int w = int'($urandom_range(0, 12));
            int h = (s % 7 == 3) ? l - 1 : ((l + w > 4095) ? 4095 : l + w);
            cfg(l, h < 0 ? 0 : h, $urandom_range(0, 1), $urandom_range(0, 1),
                (s % 9 == 5) ? 0 : $urandom_range(1, 4));
            start = 1;
            step();
            run_to_idle(1, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
